// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline register family: control bit indices and EX/MEM payload layout.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package pipe_pkg;

    // Control vector as used by the EX/MEM stage.
    localparam int CTRL_W_EXMEM  = 6;
    localparam int CTRL_BRANCH   = 0;
    localparam int CTRL_MEMREAD  = 1;
    localparam int CTRL_MEMTOREG = 2;
    localparam int CTRL_MEMWRITE = 3;
    localparam int CTRL_REGWRITE = 4;
    localparam int CTRL_ADDERSEL = 5;

    typedef logic [CTRL_W_EXMEM-1:0] pipe_ctrl_t;

    // EX/MEM payload packing: adder | alu | writedata | zero.
    localparam int ADDER_LSB = 0;
    localparam int ALU_LSB   = 64;
    localparam int WDATA_LSB = 128;
    localparam int ZERO_BIT  = 192;

    // Population count of up to four slot valid bits.
    function automatic logic [2:0] occ_count(input logic [3:0] vld);
        logic [2:0] sum;
        sum = 3'd0;
        for (int i = 0; i < 4; i++) begin
            sum = sum + {2'b00, vld[i]};
        end
        return sum;
    endfunction

endpackage

// File: rtl/pipe_slot.sv
// One pipeline slot holding valid, payload, rd and control bits.
// Latency: 1 cycle from load to output.
// Backpressure: hold_i freezes the slot; squash_i clears valid/rd/ctrl but keeps payload.
module pipe_slot #(
    parameter int PAYLOAD_W = 193,
    parameter int RD_W      = 5,
    parameter int CTRL_W    = 6
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 squash_i,
    input  logic                 hold_i,
    input  logic                 valid_i,
    input  logic [PAYLOAD_W-1:0] payload_i,
    input  logic [RD_W-1:0]      rd_i,
    input  logic [CTRL_W-1:0]    ctrl_i,
    output logic                 valid_o,
    output logic [PAYLOAD_W-1:0] payload_o,
    output logic [RD_W-1:0]      rd_o,
    output logic [CTRL_W-1:0]    ctrl_o
);

    logic                 valid_q,   valid_d;
    logic [PAYLOAD_W-1:0] payload_q, payload_d;
    logic [RD_W-1:0]      rd_q,      rd_d;
    logic [CTRL_W-1:0]    ctrl_q,    ctrl_d;

    // Next-state selection: squash beats hold beats load; a non-valid load becomes a canonical bubble.
    always_comb begin
        valid_d   = valid_q;
        payload_d = payload_q;
        rd_d      = rd_q;
        ctrl_d    = ctrl_q;
        if (squash_i) begin
            valid_d = 1'b0;
            rd_d    = '0;
            ctrl_d  = '0;
        end else if (!hold_i) begin
            valid_d   = valid_i;
            payload_d = payload_i;
            rd_d      = valid_i ? rd_i   : '0;
            ctrl_d    = valid_i ? ctrl_i : '0;
        end
    end

    // Slot register with synchronous reset clearing every field.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q   <= 1'b0;
            payload_q <= '0;
            rd_q      <= '0;
            ctrl_q    <= '0;
        end else begin
            valid_q   <= valid_d;
            payload_q <= payload_d;
            rd_q      <= rd_d;
            ctrl_q    <= ctrl_d;
        end
    end

    assign valid_o   = valid_q;
    assign payload_o = payload_q;
    assign rd_o      = rd_q;
    assign ctrl_o    = ctrl_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Parametrised pipeline register: DEPTH chained slots with stall, flush, occupancy and perf counters.
// Latency: DEPTH cycles capture-to-output, plus one per stalled cycle.
// Backpressure: stall holds every slot and drops the input; flush squashes every slot and wins over stall.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int PAYLOAD_W = 193,
    parameter int RD_W      = 5,
    parameter int CTRL_W    = 6,
    parameter int DEPTH     = 1,
    parameter int CNT_W     = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    input  logic [PAYLOAD_W-1:0] in_payload,
    input  logic [RD_W-1:0]      in_rd,
    input  logic [CTRL_W-1:0]    in_ctrl,
    input  logic                 stall,
    input  logic                 flush,
    output logic                 out_valid,
    output logic [PAYLOAD_W-1:0] out_payload,
    output logic [RD_W-1:0]      out_rd,
    output logic [CTRL_W-1:0]    out_ctrl,
    output logic [2:0]           occupancy,
    output logic [CNT_W-1:0]     stall_cnt,
    output logic [CNT_W-1:0]     bubble_cnt
);

    if (DEPTH < 1 || DEPTH > 4) begin : g_bad_depth
        $error("pipe_stage_reg: DEPTH must be in 1..4");
    end

    logic [DEPTH-1:0]     slot_vld;
    logic [DEPTH-1:0]     shift_vld;   // slot valid bits as they would be after an advance
    logic [PAYLOAD_W-1:0] slot_payload [DEPTH];
    logic [RD_W-1:0]      slot_rd      [DEPTH];
    logic [CTRL_W-1:0]    slot_ctrl    [DEPTH];

    for (genvar k = 0; k < DEPTH; k++) begin : g_slot
        logic                 vld_in;
        logic [PAYLOAD_W-1:0] payload_in;
        logic [RD_W-1:0]      rd_in;
        logic [CTRL_W-1:0]    ctrl_in;

        if (k == 0) begin : g_head
            assign vld_in     = in_valid;
            assign payload_in = in_payload;
            assign rd_in      = in_rd;
            assign ctrl_in    = in_ctrl;
        end else begin : g_body
            assign vld_in     = slot_vld[k-1];
            assign payload_in = slot_payload[k-1];
            assign rd_in      = slot_rd[k-1];
            assign ctrl_in    = slot_ctrl[k-1];
        end

        assign shift_vld[k] = vld_in;

        pipe_slot #(
            .PAYLOAD_W (PAYLOAD_W),
            .RD_W      (RD_W),
            .CTRL_W    (CTRL_W)
        ) u_slot (
            .clk       (clk),
            .reset     (reset),
            .squash_i  (flush),
            .hold_i    (stall),
            .valid_i   (vld_in),
            .payload_i (payload_in),
            .rd_i      (rd_in),
            .ctrl_i    (ctrl_in),
            .valid_o   (slot_vld[k]),
            .payload_o (slot_payload[k]),
            .rd_o      (slot_rd[k]),
            .ctrl_o    (slot_ctrl[k])
        );
    end

    logic [DEPTH-1:0] nxt_vld;
    logic [2:0]       occ_q,        occ_d;
    logic [CNT_W-1:0] stall_cnt_q,  stall_cnt_d;
    logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;

    // Predict the slot valid bits after this edge so occupancy lands on the same edge as the slots.
    always_comb begin
        nxt_vld = slot_vld;
        if (flush) begin
            nxt_vld = '0;
        end else if (!stall) begin
            nxt_vld = shift_vld;
        end
        occ_d = occ_count(4'(nxt_vld));
    end

    // Saturating perf counters: stalls ignore flushed cycles, bubbles count any non-stalled empty output.
    always_comb begin
        stall_cnt_d  = stall_cnt_q;
        bubble_cnt_d = bubble_cnt_q;
        if (!flush && stall && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        if (!stall && !slot_vld[DEPTH-1] && (bubble_cnt_q != '1)) begin
            bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
        end
    end

    // Occupancy and counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            occ_q        <= 3'd0;
            stall_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            occ_q        <= occ_d;
            stall_cnt_q  <= stall_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign out_valid   = slot_vld[DEPTH-1];
    assign out_payload = slot_payload[DEPTH-1];
    assign out_rd      = slot_rd[DEPTH-1];
    assign out_ctrl    = slot_ctrl[DEPTH-1];
    assign occupancy   = occ_q;
    assign stall_cnt   = stall_cnt_q;
    assign bubble_cnt  = bubble_cnt_q;

endmodule
